// File: rtl/ring_meas_sched_if.sv
// Result port of the ring measurement scheduler: a valid/ready handshake
// carrying the ring index, the edge count and the saturation flag.
interface ring_meas_sched_if #(
   parameter int CNT_W = 16
);
   logic             O_VALID;
   logic             I_READY;
   logic [2:0]       O_RING_ID;
   logic [CNT_W-1:0] O_COUNT;
   logic             O_OVF;

   modport master (
      output O_VALID, O_RING_ID, O_COUNT, O_OVF,
      input  I_READY
   );

   modport slave (
      input  O_VALID, O_RING_ID, O_COUNT, O_OVF,
      output I_READY
   );
endinterface

// File: rtl/ring_meas_sched.sv
// Ring oscillator measurement scheduler. Walks the selected rings one at a
// time: enable the ring, let it settle, count its synchronized rising edges
// over a gate window of CLK cycles, then hold the result on a valid/ready
// port. Only one ring is ever enabled. Rings faster than CLK/2 alias; this is
// not detected. SETTLE must be at least 3 so the synchronizer chain is
// flushed of the previous ring before counting starts.
module ring_meas_sched #(
   parameter int NUM_RINGS = 6,
   parameter int GATE_W    = 16,
   parameter int CNT_W     = 16,
   parameter int SETTLE    = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 I_START,
   input  logic                 I_CONT,
   input  logic [NUM_RINGS-1:0] I_SEL,
   input  logic [GATE_W-1:0]    I_GATE,
   input  logic [NUM_RINGS-1:0] I_RING,
   output logic [NUM_RINGS-1:0] O_EN,
   output logic                 O_BUSY,
   ring_meas_sched_if.master    res
);

   localparam int SET_W = $clog2(SETTLE + 1);
   localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_GATE,
      ST_REPORT
   } t_state;

   t_state               r_state;
   logic [NUM_RINGS-1:0] r_mask;
   logic [GATE_W-1:0]    r_gate;
   logic                 r_cont;
   logic [2:0]           r_id;
   logic [TMR_W-1:0]     r_tmr;
   logic [NUM_RINGS-1:0] r_en;
   logic                 r_busy;
   logic                 r_valid;
   logic [2:0]           r_rid;
   logic [CNT_W-1:0]     r_count;
   logic                 r_ovf_o;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_ovf;
   logic                 r_sync1;
   logic                 r_sync2;
   logic                 r_sync3;

   logic                 w_ring_sel;
   logic                 w_edge;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic                 w_ovf_nxt;
   logic                 w_nxt_vld;
   logic [2:0]           w_nxt_id;
   logic [2:0]           w_low_sel;
   logic [2:0]           w_low_mask;

   // Index of the lowest set bit of a ring mask (0 for an empty mask).
   function automatic logic [2:0] f_lowest(input logic [NUM_RINGS-1:0] m);
      logic [2:0] id;
      id = '0;
      for (int i = NUM_RINGS - 1; i >= 0; i--) begin
         if (m[i]) id = 3'(i);
      end
      return id;
   endfunction

   // One-hot enable pattern for a ring index.
   function automatic logic [NUM_RINGS-1:0] f_onehot(input logic [2:0] id);
      return NUM_RINGS'(1) << id;
   endfunction

   assign w_ring_sel = I_RING[r_id];
   assign w_edge     = r_sync2 & ~r_sync3;
   assign w_low_sel  = f_lowest(I_SEL);
   assign w_low_mask = f_lowest(r_mask);

   // Next selected ring strictly above the current one, if any.
   always_comb begin
      w_nxt_vld = 1'b0;
      w_nxt_id  = '0;
      for (int i = NUM_RINGS - 1; i >= 0; i--) begin
         if (r_mask[i] && (i > int'(r_id))) begin
            w_nxt_vld = 1'b1;
            w_nxt_id  = 3'(i);
         end
      end
   end

   // Saturating edge counter update; a dropped edge at full scale flags overflow.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_ovf_nxt = r_ovf;
      if (w_edge) begin
         if (&r_cnt) w_ovf_nxt = 1'b1;
         else        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   // Synchronizer, edge counter and scheduling FSM with registered outputs.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state <= ST_IDLE;
         r_mask  <= '0;
         r_gate  <= '0;
         r_cont  <= 1'b0;
         r_id    <= '0;
         r_tmr   <= '0;
         r_en    <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_rid   <= '0;
         r_count <= '0;
         r_ovf_o <= 1'b0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= w_ring_sel;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         case (r_state)
            ST_IDLE: begin
               if (I_START && (|I_SEL)) begin
                  r_mask  <= I_SEL;
                  r_gate  <= (I_GATE == '0) ? GATE_W'(1) : I_GATE;
                  r_cont  <= I_CONT;
                  r_id    <= w_low_sel;
                  r_en    <= f_onehot(w_low_sel);
                  r_tmr   <= TMR_W'(SETTLE - 1);
                  r_busy  <= 1'b1;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_tmr == '0) begin
                  r_tmr   <= TMR_W'(r_gate - GATE_W'(1));
                  r_cnt   <= '0;
                  r_ovf   <= 1'b0;
                  r_state <= ST_GATE;
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            ST_GATE: begin
               r_cnt <= w_cnt_nxt;
               r_ovf <= w_ovf_nxt;
               if (r_tmr == '0) begin
                  r_en    <= '0;
                  r_valid <= 1'b1;
                  r_rid   <= r_id;
                  r_count <= w_cnt_nxt;
                  r_ovf_o <= w_ovf_nxt;
                  r_state <= ST_REPORT;
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            ST_REPORT: begin
               if (res.I_READY) begin
                  r_valid <= 1'b0;
                  if (w_nxt_vld) begin
                     r_id    <= w_nxt_id;
                     r_en    <= f_onehot(w_nxt_id);
                     r_tmr   <= TMR_W'(SETTLE - 1);
                     r_state <= ST_SETTLE;
                  end else if (r_cont && I_START) begin
                     r_id    <= w_low_mask;
                     r_en    <= f_onehot(w_low_mask);
                     r_tmr   <= TMR_W'(SETTLE - 1);
                     r_state <= ST_SETTLE;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign O_EN          = r_en;
   assign O_BUSY        = r_busy;
   assign res.O_VALID   = r_valid;
   assign res.O_RING_ID = r_rid;
   assign res.O_COUNT   = r_count;
   assign res.O_OVF     = r_ovf_o;

endmodule

// File: doc/ring_meas_sched.md
Name: ring_meas_sched

Overview:
- Measurement scheduler for the bank of ring oscillators (5/11/23/47/97/197 stages).
- Sequences through a software-selected subset of rings, one at a time. For each ring it:
  - enables only that ring,
  - waits a settle interval,
  - counts rising edges of the ring output over a programmable gate window of CLK cycles,
  - presents the count on a valid/ready result port.
- Sits between the ring bank and the readout logic. Only one ring oscillates at any time, so there is no cross-ring coupling or supply noise between rings.

Parameters:
- NUM_RINGS, 6, number of ring oscillators managed (ring index 0..NUM_RINGS-1).
- GATE_W, 16, width of the gate-window length input.
- CNT_W, 16, width of the edge counter and result.
- SETTLE, 8, CLK cycles a ring is enabled before counting starts. Must be >= 3 so the synchronizer is flushed.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset: synchronous, active-low; state changes only on the CLK rising edge while RST=0.
- I_START  input  1  level; request a measurement sequence.
- I_CONT  input  1  1 = continuous scanning, 0 = single pass.
- I_SEL  input  NUM_RINGS  mask of rings to measure.
- I_GATE  input  GATE_W  gate window length in CLK cycles.
- I_RING  input  NUM_RINGS  raw ring oscillator outputs (asynchronous to CLK).
- I_READY  input  1  consumer accepts the current result.
- O_EN  output  NUM_RINGS  one-hot ring enable (all-zero when no ring is active).
- O_VALID  output  1  result valid.
- O_RING_ID  output  3  index of the ring the result belongs to.
- O_COUNT  output  CNT_W  rising-edge count over the gate window.
- O_OVF  output  1  count saturated during this window.
- O_BUSY  output  1  FSM not in IDLE.

Behaviour:
- Reset (RST=0 at a CLK edge):
  - FSM goes to IDLE.
  - O_EN=0, O_VALID=0, O_RING_ID=0, O_COUNT=0, O_OVF=0, O_BUSY=0.
  - Synchronizer and counter are cleared.
  - Reset mid-measurement aborts immediately; no result is emitted.
- States and transitions:
  - IDLE:
    - If I_START=1 and I_SEL!=0: latch I_SEL, I_GATE (0 is treated as 1) and I_CONT; set ring_id to the lowest set bit of the mask; go to SETTLE.
    - If I_SEL=0: I_START is ignored and the FSM stays in IDLE.
  - SETTLE:
    - O_EN has one-hot bit ring_id set from the first SETTLE cycle.
    - Lasts exactly SETTLE cycles, then go to GATE. The counter is cleared on entry to GATE.
  - GATE:
    - Lasts exactly the latched gate number of cycles; O_EN stays asserted.
    - Counting path: I_RING[ring_id] is muxed into a 2-flop synchronizer, then an edge-detect flop. The counter increments on each cycle where sync2=1 and sync3=0.
    - Saturation: the counter saturates at 2^CNT_W-1 and sets the ovf flag.
    - Next: go to REPORT.
  - REPORT:
    - O_EN=0 (ring stopped).
    - O_VALID=1, with O_RING_ID, O_COUNT and O_OVF held stable until a cycle where I_READY=1.
    - On the handshake cycle O_VALID drops the next cycle, and the FSM picks the next set mask bit strictly above ring_id:
      - If one exists, go to SETTLE with that ring.
      - If none and the latched I_CONT=1 and I_START is still 1: wrap to the lowest set bit and go to SETTLE.
      - Otherwise go to IDLE.
- Latency:
  - First O_VALID rises SETTLE+gate+1 cycles after the IDLE cycle that accepted START.
  - Back-to-back rings are separated by SETTLE+gate+1 cycles after each handshake.
- Configuration timing:
  - Mask, gate and mode are latched only in IDLE. Changes mid-sequence take effect at the next start.
  - Exception: I_START=0 in continuous mode ends the sequence after the next wrap point.
- Boundary conditions:
  - I_READY already high when REPORT is entered: handshake in the first REPORT cycle, so O_VALID is high for exactly 1 cycle.
  - Single-bit mask in continuous mode: the same ring is re-measured repeatedly.
  - O_EN is never multi-hot. O_EN is never nonzero in IDLE or REPORT.
  - O_BUSY=1 in SETTLE, GATE and REPORT.
- Frequency limit: rings with frequency above CLK/2 alias. This limit is documented, not detected.

Test Plan:
- Reset/idle:
  - Stimulus: hold RST=0 for 3 cycles with I_START=1, I_SEL=6'h3F.
  - Required: all outputs 0. After RST=1 and START, O_EN=6'b000001 from the first SETTLE cycle.
- Single ring:
  - Stimulus: I_SEL=6'b000100, I_GATE=100, I_CONT=0, I_READY=1; bench toggles I_RING[2] with a period of 10 CLK.
  - Required: O_VALID pulses once, SETTLE+101 cycles after start, with O_RING_ID=2, O_COUNT=10, O_OVF=0. Then IDLE, O_BUSY=0.
- Multi-ring scan with backpressure:
  - Stimulus: I_SEL=6'b100001, gate 50; ring0 period 5, ring5 period 25; I_READY held 0 for 7 cycles on the first result.
  - Required:
    - O_COUNT=10 for ring 0, stable across the stall.
    - Then ring 5 is measured with O_COUNT=2.
    - O_EN is never asserted for other rings.
- Saturation:
  - Stimulus: CNT_W=4, gate 200, ring period 4.
  - Required: O_COUNT=15, O_OVF=1.
- Continuous plus stop:
  - Stimulus: I_SEL=6'b000011, I_CONT=1.
  - Required: result sequence 0,1,0,1. Deasserting I_START during ring 0 of the 2nd pass stops the scan after ring 1's result is accepted.
- Abort/edge cases:
  - Stimulus: assert RST=0 mid-GATE, then start with I_SEL=0, then start with I_GATE=0.
  - Required:
    - After the mid-GATE reset: no O_VALID, O_EN=0 next cycle.
    - I_SEL=0: start is ignored.
    - I_GATE=0: a 1-cycle window, O_COUNT ≤ 1.
